// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the instruction fetch unit   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

package fetch_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FAULT_PEND = 2'd1,
        HALT       = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic        fault;
    } fetch_entry_t;

    localparam int INST_BYTES = 4;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'(INST_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_buffer: synchronous FIFO of fetch entries with flush priority    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [2:0]   count
);

    localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX   = PW'(DEPTH - 1);
    localparam logic [2:0]    FULL_COUNT = 3'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [2:0]    r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = pop & ~flush & (r_count != 3'd0);
    assign w_push = push & ~flush & ((r_count != FULL_COUNT) | w_pop);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 3'd0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= wrap_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= wrap_inc(r_rd_ptr);
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Storage is cleared on reset so the head reads as all-zero until first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instruction_fetch: fetch address, memory request/response tracking,    |
// | instruction buffer and redirect handling. Optional misaligned-target   |
// | fault path enabled by defining IFETCH_ALIGN_CHECK_EN.                  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_address,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_address,
    output logic        inst_fault
);

    localparam logic [3:0] CREDIT_LIMIT = 4'(BUF_DEPTH);
    localparam logic [2:0] BUF_FULL     = 3'(BUF_DEPTH);

    logic [31:0]  r_fetch_addr;
    logic [2:0]   r_outstanding;
    logic [2:0]   r_discard;
    logic [2:0]   w_buf_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic [31:0]  w_target;
    logic [31:0]  w_resp_addr;
    logic [3:0]   w_used;
    logic         w_run;
    logic         w_fault_push;
    logic         w_accept;
    logic         w_resp_keep;
    logic         w_resp_drop;
    logic         w_push;
    logic         w_pop;
    logic         w_pop_credit;

`ifdef IFETCH_ALIGN_CHECK_EN
    fetch_state_t r_state;

    assign w_target     = redirect_address;
    assign w_run        = (r_state == RUN);
    assign w_fault_push = (r_state == FAULT_PEND) & ~redirect_valid &
                          (r_discard == 3'd0) & (w_buf_count < BUF_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else if (redirect_valid) begin
            r_state <= (redirect_address[1:0] != 2'b00) ? FAULT_PEND : RUN;
        end else if (w_fault_push) begin
            r_state <= HALT;
        end
    end
`else
    assign w_target     = redirect_address & ~32'h3;
    assign w_run        = 1'b1;
    assign w_fault_push = 1'b0;
`endif

    // A consume this cycle frees its slot immediately so a steady stream runs at one per cycle.
    assign w_pop_credit  = inst_valid & inst_ready;
    assign w_used        = {1'b0, r_outstanding} + {1'b0, r_discard} + {1'b0, w_buf_count}
                         - {3'b000, w_pop_credit};
    assign mem_req_valid = rst_n & w_run & ~redirect_valid & (w_used < CREDIT_LIMIT);
    assign mem_req_address = r_fetch_addr;
    assign w_accept      = mem_req_valid & mem_req_ready;

    // Live requests are sequential from the oldest, so the response address is recoverable.
    assign w_resp_addr   = r_fetch_addr - {27'd0, r_outstanding, 2'b00};
    assign w_resp_drop   = mem_resp_valid & (r_discard != 3'd0);
    assign w_resp_keep   = mem_resp_valid & (r_discard == 3'd0) & ~redirect_valid;

    assign w_push        = w_resp_keep | w_fault_push;
    assign w_push_entry  = w_fault_push ? '{data: 32'd0, address: r_fetch_addr, fault: 1'b1}
                                        : '{data: mem_resp_data, address: w_resp_addr, fault: 1'b0};
    assign w_pop         = inst_valid & inst_ready & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_addr  <= RESET_ADDR;
            r_outstanding <= 3'd0;
            r_discard     <= 3'd0;
        end else if (redirect_valid) begin
            r_fetch_addr  <= w_target;
            r_outstanding <= 3'd0;
            r_discard     <= r_outstanding + r_discard + {2'b00, w_accept}
                           - {2'b00, mem_resp_valid};
        end else begin
            if (w_accept) r_fetch_addr <= next_word(r_fetch_addr);
            r_outstanding <= r_outstanding + {2'b00, w_accept} - {2'b00, w_resp_keep};
            if (w_resp_drop) r_discard <= r_discard - 3'd1;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .head       (w_head),
        .count      (w_buf_count)
    );

    assign inst_valid   = (w_buf_count != 3'd0);
    assign inst_data    = w_head.data;
    assign inst_address = w_head.address;
    // Only the fault path ever writes a set fault bit, so this is constant 0 without it.
    assign inst_fault   = w_head.fault;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_instruction_fetch: directed scoreboard bench for instruction_fetch  |
// | (adapts expectations when IFETCH_ALIGN_CHECK_EN is defined).           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_address;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_address;
    logic        inst_fault;
    logic        resp_en;

    int           errors   = 0;
    int           checks   = 0;
    int           n_accept = 0;
    int           a0;
    logic [31:0]  model_pc;
    logic         halted;
    fetch_entry_t exp_q[$];
    logic [31:0]  memq[$];

    instruction_fetch #(
        .RESET_ADDR (RESET_ADDR),
        .BUF_DEPTH  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_address (redirect_address),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_address  (mem_req_address),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .inst_address     (inst_address),
        .inst_fault       (inst_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    // In-order memory: a request accepted at an edge returns data in the next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memq.delete();
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= 32'd0;
        end else begin
            if (mem_req_valid && mem_req_ready) memq.push_back(mem_req_address);
            if (resp_en && memq.size() > 0) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= mem_word(memq.pop_front());
            end else begin
                mem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs at the falling edge: predicts what the coming rising edge does.
    task automatic monitor();
        fetch_entry_t e;
        if (!rst_n) begin
            exp_q.delete();
            model_pc = RESET_ADDR;
            halted   = 1'b0;
            return;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=%h expected=none", inst_address);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_addr",  inst_address, e.address);
                check("sb_data",  inst_data,    e.data);
                check("sb_fault", {31'd0, inst_fault}, {31'd0, e.fault});
            end
        end
        if (redirect_valid) begin
            check("req_in_redirect", {31'd0, mem_req_valid}, 32'd0);
            exp_q.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
            if (redirect_address[1:0] != 2'b00) begin
                exp_q.push_back('{data: 32'd0, address: redirect_address, fault: 1'b1});
                halted = 1'b1;
            end else begin
                model_pc = redirect_address;
                halted   = 1'b0;
            end
`else
            model_pc = redirect_address & ~32'h3;
`endif
        end else if (mem_req_valid && mem_req_ready) begin
            checks++;
            assert (!halted) else begin
                errors++;
                $error("FAIL req_while_halted observed=%h expected=none", mem_req_address);
            end
            check("req_addr", mem_req_address, model_pc);
            exp_q.push_back('{data: mem_word(model_pc), address: model_pc, fault: 1'b0});
            model_pc = model_pc + 32'd4;
            n_accept++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        #1;
        while (!inst_valid && n < max) begin
            cycle();
            #1;
            n++;
        end
        check("wait_inst_valid", {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_req_valid",  {31'd0, mem_req_valid}, 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        check("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
        check("first_req_addr",  mem_req_address, RESET_ADDR);
    endtask

    initial begin
        rst_n            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_address = 32'd0;
        mem_req_ready    = 1'b1;
        inst_ready       = 1'b1;
        resp_en          = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_req_valid",  {31'd0, mem_req_valid}, 32'd0);
        check("reset_req_addr",   mem_req_address, RESET_ADDR);
        check("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_inst_data",  inst_data, 32'd0);
        check("reset_inst_addr",  inst_address, 32'd0);
        check("reset_inst_fault", {31'd0, inst_fault}, 32'd0);

        // Stream from reset: one instruction per cycle.
        do_reset();
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", {31'd0, inst_valid}, 32'd1);
            check("stream_addr",  inst_address, 32'(i * 4));
            cycle();
        end

        // Memory stalls the first request for five cycles.
        mem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("stall_req_valid",  {31'd0, mem_req_valid}, 32'd1);
            check("stall_req_addr",   mem_req_address, 32'h0);
            check("stall_inst_valid", {31'd0, inst_valid}, 32'd0);
            cycle();
        end
        mem_req_ready = 1'b1;
        #1;
        cycle();
        cycle();
        check("stall_resume_addr", inst_address, 32'h0);
        repeat (3) cycle();

        // Decode backpressure: credits cap the accepted requests.
        inst_ready = 1'b0;
        do_reset();
        a0 = n_accept;
        repeat (6) cycle();
        check("bp_accepts",     32'(n_accept - a0), 32'd2);
        check("bp_req_valid",   {31'd0, mem_req_valid}, 32'd0);
        check("bp_head_addr",   inst_address, 32'h0);
        inst_ready = 1'b1;
        #1;
        check("bp_resume_req",  {31'd0, mem_req_valid}, 32'd1);
        cycle();
        check("bp_next_head",   inst_address, 32'h4);
        repeat (4) cycle();

        // Redirect with 0x8 and 0xC outstanding.
        do_reset();
        cycle();
        cycle();
        resp_en = 1'b0;
        cycle();
        cycle();
        check("rd_credit_stop", {31'd0, mem_req_valid}, 32'd0);
        redirect_valid   = 1'b1;
        redirect_address = 32'h100;
        resp_en          = 1'b1;
        #1;
        cycle();
        redirect_valid = 1'b0;
        wait_valid(12);
        check("rd_first_addr", inst_address, 32'h100);

        // Redirect coinciding with a response and a consume.
        repeat (3) cycle();
        check("rc_pre_valid", {31'd0, inst_valid}, 32'd1);
        redirect_valid   = 1'b1;
        redirect_address = 32'h100;
        #1;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("rc_buf_empty",  {31'd0, inst_valid}, 32'd0);
        check("rc_req_valid",  {31'd0, mem_req_valid}, 32'd1);
        check("rc_req_addr",   mem_req_address, 32'h100);
        wait_valid(8);
        check("rc_first_addr", inst_address, 32'h100);

        // Misaligned redirect.
        repeat (3) cycle();
        redirect_valid   = 1'b1;
        redirect_address = 32'h102;
        #1;
        cycle();
        redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        #1;
        check("mis_no_req", {31'd0, mem_req_valid}, 32'd0);
        wait_valid(8);
        check("mis_fault",  {31'd0, inst_fault}, 32'd1);
        check("mis_addr",   inst_address, 32'h102);
        check("mis_data",   inst_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("halt_no_req",   {31'd0, mem_req_valid}, 32'd0);
            check("halt_no_inst",  {31'd0, inst_valid}, 32'd0);
        end
        redirect_valid   = 1'b1;
        redirect_address = 32'h200;
        #1;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("resume_req_addr", mem_req_address, 32'h200);
        wait_valid(8);
        check("resume_addr", inst_address, 32'h200);
`else
        #1;
        check("mis_req_valid", {31'd0, mem_req_valid}, 32'd1);
        check("mis_req_addr",  mem_req_address, 32'h100);
        wait_valid(8);
        check("mis_addr",  inst_address, 32'h100);
        check("mis_fault", {31'd0, inst_fault}, 32'd0);
`endif

        // Address wrap at the top of the address space.
        repeat (3) cycle();
        redirect_valid   = 1'b1;
        redirect_address = 32'hFFFF_FFF8;
        #1;
        cycle();
        redirect_valid = 1'b0;
        wait_valid(8);
        check("wrap_addr0", inst_address, 32'hFFFF_FFF8);
        cycle();
        check("wrap_addr1", inst_address, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr2", inst_address, 32'h0000_0000);
        cycle();
        check("wrap_addr3", inst_address, 32'h0000_0004);
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
